quad_decoder: RTL

QUAD_DECODER -- requirements
Module: quad_decoder

---
 rtl/quad_decoder_if.sv | 26 ++
 rtl/quad_decoder.sv | 137 +++++++++++++
 2 files changed

// File: rtl/quad_decoder_if.sv
// Quadrature decoder bus: control inputs, raw A/B phases and registered results.
//   master : drives en, clr, err_clr, a_in, b_in; observes count, dir, step, err
//   slave  : the decoder side of the same signals
interface quad_decoder_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             en;
    logic             clr;
    logic             err_clr;
    logic             a_in;
    logic             b_in;
    logic [WIDTH-1:0] count;
    logic             dir;
    logic             step;
    logic             err;

    modport master (
        output en, clr, err_clr, a_in, b_in,
        input  count, dir, step, err
    );

    modport slave (
        input  en, clr, err_clr, a_in, b_in,
        output count, dir, step, err
    );
endinterface

// File: rtl/quad_decoder.sv
// Quadrature decoder: synchronizes A/B, decodes single-bit phase steps into an
// up/down modulo-2^WIDTH count, flags double-bit jumps as a sticky error.
// Ports:
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   bus      : quad_decoder_if.slave (en, clr, err_clr, a_in, b_in in;
//              count, dir, step, err out, all registered)
module quad_decoder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    quad_decoder_if.slave bus
);

    typedef enum logic [1:0] {
        PRIME0 = 2'd0,
        PRIME1 = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [1:0]       r_s1;
    logic [1:0]       r_s2;
    logic [1:0]       r_prev;
    logic [1:0]       w_prev_nxt;

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             r_step;
    logic             w_step_nxt;
    logic             r_err;
    logic             w_err_nxt;

    logic             w_up;
    logic             w_dn;
    logic             w_bad;

    // Classify the prev -> current phase transition
    always_comb begin
        w_up  = 1'b0;
        w_dn  = 1'b0;
        w_bad = 1'b0;
        case ({r_prev, r_s2})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: w_up  = 1'b1;
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: w_dn  = 1'b1;
            4'b00_11, 4'b11_00, 4'b01_10, 4'b10_01: w_bad = 1'b1;
            default: ;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PRIME0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath next values
    always_comb begin
        w_state_nxt = r_state;
        w_prev_nxt  = r_s2;
        w_count_nxt = r_count;
        w_dir_nxt   = r_dir;
        w_step_nxt  = 1'b0;
        w_err_nxt   = r_err;

        if (bus.err_clr) begin
            w_err_nxt = 1'b0;
        end

        case (r_state)
            // While priming, prev is loaded from s1, i.e. the value s2 takes at
            // this same edge, so prev == s2 on entry to RUN regardless of the
            // input levels at reset release.
            PRIME0: begin
                w_prev_nxt  = r_s1;
                w_state_nxt = PRIME1;
            end
            PRIME1: begin
                w_prev_nxt  = r_s1;
                w_state_nxt = RUN;
            end
            RUN: begin
                if (w_bad) begin
                    w_err_nxt = 1'b1;
                end
                if (bus.en && (w_up || w_dn)) begin
                    w_step_nxt  = 1'b1;
                    w_dir_nxt   = w_up;
                    w_count_nxt = w_up ? (r_count + WIDTH'(1)) : (r_count - WIDTH'(1));
                end
            end
            default: begin
                w_state_nxt = PRIME0;
            end
        endcase

        // Clear overrides the count only; dir and step still reflect the step
        if (bus.clr) begin
            w_count_nxt = '0;
        end
    end

    // Synchronizers and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1    <= 2'b00;
            r_s2    <= 2'b00;
            r_prev  <= 2'b00;
            r_count <= '0;
            r_dir   <= 1'b1;
            r_step  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_s1    <= {bus.a_in, bus.b_in};
            r_s2    <= r_s1;
            r_prev  <= w_prev_nxt;
            r_count <= w_count_nxt;
            r_dir   <= w_dir_nxt;
            r_step  <= w_step_nxt;
            r_err   <= w_err_nxt;
        end
    end

    assign bus.count = r_count;
    assign bus.dir   = r_dir;
    assign bus.step  = r_step;
    assign bus.err   = r_err;

endmodule
